// File: rtl/spi_byte_master_if.sv
// Byte handshake between the SPI control FSM (master side) and the byte engine (slave side).
interface spi_byte_master_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (
        output tx_data, tx_valid, tx_last,
        input  tx_ready, rx_data, rx_valid
    );

    modport slave (
        input  tx_data, tx_valid, tx_last,
        output tx_ready, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_byte_master.sv
// Mode-0 SPI byte engine: frames bytes under cs, MSB first, returns each received byte as a pulse.
module spi_byte_master #(
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    spi_byte_master_if.slave  bus,
    output logic              sclk_o,
    output logic              mosi_o,
    input  logic              miso_i,
    output logic              cs_o,
    output logic              frame_active_o
);
    typedef enum logic [2:0] {GAP, IDLE, SHIFT, TRAIL, WAIT} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state_q;
    logic [7:0] cnt_q;
    logic [2:0] bit_q;
    logic [6:0] tx_sr_q;
    logic [7:0] rx_sr_q;
    logic [7:0] rx_data_q;
    logic       last_q;
    logic       sclk_q;
    logic       mosi_q;
    logic       cs_q;
    logic       rx_valid_q;
    logic       tx_ready;
    logic       accept;

    // Ready is the only output decoded straight from state.
    assign tx_ready       = (state_q == IDLE) || (state_q == WAIT);
    assign accept         = bus.tx_valid && tx_ready;
    assign bus.tx_ready   = tx_ready;
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign sclk_o         = sclk_q;
    assign mosi_o         = mosi_q;
    assign cs_o           = cs_q;
    assign frame_active_o = ~cs_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= GAP;
            cnt_q      <= 8'd0;
            bit_q      <= 3'd0;
            tx_sr_q    <= 7'd0;
            rx_sr_q    <= 8'd0;
            rx_data_q  <= 8'h00;
            last_q     <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_q       <= 1'b1;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                GAP: begin
                    if (cnt_q == DIV_LAST) begin
                        cnt_q   <= 8'd0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                IDLE, WAIT: begin
                    if (accept) begin
                        tx_sr_q <= bus.tx_data[6:0];
                        mosi_q  <= bus.tx_data[7];
                        last_q  <= bus.tx_last;
                        cs_q    <= 1'b0;
                        bit_q   <= 3'd7;
                        cnt_q   <= 8'd0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt_q != DIV_LAST) begin
                        cnt_q <= cnt_q + 8'd1;
                    end else begin
                        cnt_q <= 8'd0;
                        if (!sclk_q) begin
                            sclk_q  <= 1'b1;
                            rx_sr_q <= {rx_sr_q[6:0], miso_i};
                        end else begin
                            sclk_q <= 1'b0;
                            // Falling edge of bit 0 closes the byte instead of shifting.
                            if (bit_q == 3'd0) begin
                                rx_data_q  <= rx_sr_q;
                                rx_valid_q <= 1'b1;
                                mosi_q     <= 1'b0;
                                state_q    <= last_q ? TRAIL : WAIT;
                            end else begin
                                bit_q   <= bit_q - 3'd1;
                                mosi_q  <= tx_sr_q[6];
                                tx_sr_q <= {tx_sr_q[5:0], 1'b0};
                            end
                        end
                    end
                end
                TRAIL: begin
                    if (cnt_q == DIV_LAST) begin
                        cnt_q   <= 8'd0;
                        cs_q    <= 1'b1;
                        state_q <= GAP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= GAP;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_byte_master.sv
// Bench for spi_byte_master: per-cycle waveforms of each byte compared with a cycle-indexed model.
`timescale 1ns/1ps
module tb_spi_byte_master;
    localparam int D  = 2;
    localparam int D1 = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_byte_master_if bus ();
    spi_byte_master_if bus1 ();

    logic sclk, mosi, miso, cs, fa;
    logic sclk1, mosi1, cs1, fa1;

    spi_byte_master #(.CLK_DIV(D)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .sclk_o(sclk), .mosi_o(mosi), .miso_i(miso), .cs_o(cs), .frame_active_o(fa)
    );

    spi_byte_master #(.CLK_DIV(D1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .sclk_o(sclk1), .mosi_o(mosi1), .miso_i(1'b0), .cs_o(cs1), .frame_active_o(fa1)
    );

    // Slave model: loopback of mosi, or a byte presented MSB first and advanced on sclk falls.
    logic       miso_mode = 1'b0;
    logic [7:0] slv = 8'h00;
    logic [2:0] sidx = 3'd0;
    always @(negedge sclk or posedge cs)
        if (cs) sidx <= 3'd0;
        else    sidx <= sidx + 3'd1;
    assign miso = miso_mode ? slv[~sidx] : mosi;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (bus.tx_ready !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk(tag, bus.tx_ready, 1'b1);
    endtask

    // Sends one byte and checks every cycle from the accept edge up to the next ready cycle.
    task automatic xfer(input logic [7:0] d, input logic last, input logic hold, input logic pend);
        logic [63:0] o_sclk, o_mosi, o_cs, o_fa, o_rdy, o_rxv;
        logic [63:0] e_sclk, e_mosi, e_cs, e_fa, e_rdy, e_rxv;
        logic [7:0]  e_rx, o_rx;
        int n, idx;
        e_rx = miso_mode ? slv : d;
        o_rx = ~e_rx;
        n = last ? 18 * D + 1 : 16 * D + 1;
        o_sclk = '0; o_mosi = '0; o_cs = '0; o_fa = '0; o_rdy = '0; o_rxv = '0;
        e_sclk = '0; e_mosi = '0; e_cs = '0; e_fa = '0; e_rdy = '0; e_rxv = '0;
        bus.tx_data  = d;
        bus.tx_last  = last;
        bus.tx_valid = 1'b1;
        wait_ready("accept_ready");
        for (int k = 1; k <= n; k++) begin
            step();
            if (k == 1 && !hold) bus.tx_valid = 1'b0;
            if (k == 3 && pend) begin
                bus.tx_data  = 8'h12;
                bus.tx_last  = 1'b1;
                bus.tx_valid = 1'b1;
            end
            o_sclk[k] = sclk;
            o_mosi[k] = mosi;
            o_cs[k]   = cs;
            o_fa[k]   = fa;
            o_rdy[k]  = bus.tx_ready;
            o_rxv[k]  = bus.rx_valid;
            if (bus.rx_valid === 1'b1) o_rx = bus.rx_data;
            idx = (k <= 16 * D) ? 7 - (k - 1) / (2 * D) : 0;
            e_sclk[k] = (k <= 16 * D) && (((k - 1) / D) % 2 == 1);
            e_mosi[k] = (k <= 16 * D) ? d[idx] : 1'b0;
            e_cs[k]   = (k > 17 * D);
            e_fa[k]   = !(k > 17 * D);
            e_rdy[k]  = (k == n);
            e_rxv[k]  = (k == 16 * D + 1);
        end
        chk("sclk_wave", o_sclk, e_sclk);
        chk("mosi_wave", o_mosi, e_mosi);
        chk("cs_wave", o_cs, e_cs);
        chk("frame_active_wave", o_fa, e_fa);
        chk("tx_ready_wave", o_rdy, e_rdy);
        chk("rx_valid_wave", o_rxv, e_rxv);
        chk("rx_data_pulse", o_rx, e_rx);
        chk("rx_data_hold", bus.rx_data, e_rx);
    endtask

    logic [7:0] rd;
    logic       rlast, rhold;
    int         gap, n, bad, rises, p1, p2, np, cs_hi;
    logic       prev, rxv_seen;
    logic [7:0] rx1, rx2;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.tx_data = 8'h00;  bus.tx_last = 1'b0;  bus.tx_valid = 1'b0;
        bus1.tx_data = 8'h00; bus1.tx_last = 1'b0; bus1.tx_valid = 1'b0;

        // Reset values and release latency
        repeat (3) step();
        chk("reset_outputs", {cs, sclk, mosi, bus.tx_ready, bus.rx_valid, fa, bus.rx_data},
            {1'b1, 5'b00000, 8'h00});
        rst = 1'b0;
        n = 0;
        while (bus.tx_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("reset_release_edges", n, D);

        // Single byte, loopback
        miso_mode = 1'b0;
        xfer(8'hA5, 1'b1, 1'b0, 1'b0);

        // Backpressure: 0x12 offered during the previous byte's shift
        xfer(8'h5A, 1'b0, 1'b0, 1'b1);
        xfer(8'h12, 1'b1, 1'b0, 1'b0);

        // Slave drives 0xC3 while master sends 0x00
        miso_mode = 1'b1;
        slv = 8'hC3;
        xfer(8'h00, 1'b1, 1'b0, 1'b0);
        miso_mode = 1'b0;

        // Open frame stall
        xfer(8'h81, 1'b0, 1'b0, 1'b0);
        bad = 0;
        repeat (50) begin
            step();
            if (cs !== 1'b0 || sclk !== 1'b0 || mosi !== 1'b0 || bus.tx_ready !== 1'b1) bad++;
        end
        chk("stall_bad_cycles", bad, 0);
        xfer(8'h7E, 1'b1, 1'b0, 1'b0);

        // Randomised bytes, frames, slave data and gaps
        for (int i = 0; i < 12; i++) begin
            rd        = 8'($urandom);
            rlast     = (i == 11) ? 1'b1 : 1'($urandom_range(0, 1));
            rhold     = (i == 11) ? 1'b0 : 1'($urandom_range(0, 1));
            gap       = rhold ? 0 : $urandom_range(0, 3);
            miso_mode = 1'($urandom_range(0, 1));
            slv       = 8'($urandom);
            xfer(rd, rlast, rhold, 1'b0);
            repeat (gap) step();
        end
        bus.tx_valid = 1'b0;
        miso_mode = 1'b0;

        // Asynchronous reset after the third sclk rise
        bus.tx_data = 8'hB7; bus.tx_last = 1'b1; bus.tx_valid = 1'b1;
        wait_ready("mid_accept_ready");
        step();
        bus.tx_valid = 1'b0;
        rises = 0;
        prev = sclk;
        n = 0;
        while (rises < 3 && n < 100) begin
            step();
            if (sclk && !prev) rises++;
            prev = sclk;
            n++;
        end
        chk("mid_rises", rises, 3);
        rst = 1'b1;
        #1;
        chk("mid_async_outputs", {cs, sclk, mosi, bus.tx_ready, fa}, 5'b10000);
        rxv_seen = 1'b0;
        repeat (3) begin
            step();
            rxv_seen |= bus.rx_valid;
        end
        rst = 1'b0;
        n = 0;
        while (bus.tx_ready !== 1'b1 && n < 50) begin
            step();
            rxv_seen |= bus.rx_valid;
            n++;
        end
        chk("mid_release_edges", n, D);
        chk("mid_no_rx_valid", rxv_seen, 1'b0);
        chk("mid_rx_data", bus.rx_data, 8'h00);

        // CLK_DIV=1 back-to-back frame 0x3C, 0xFF with tx_valid held, miso tied low
        bus1.tx_data = 8'h3C; bus1.tx_last = 1'b0; bus1.tx_valid = 1'b1;
        n = 0;
        while (bus1.tx_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("b2b_ready", bus1.tx_ready, 1'b1);
        p1 = 0; p2 = 0; np = 0; cs_hi = -1; rx1 = 8'hFF; rx2 = 8'hFF;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k == 1) begin
                bus1.tx_data = 8'hFF;
                bus1.tx_last = 1'b1;
            end
            if (k == 18) bus1.tx_valid = 1'b0;
            if (bus1.rx_valid === 1'b1) begin
                np++;
                if (np == 1) begin p1 = k; rx1 = bus1.rx_data; end
                else         begin p2 = k; rx2 = bus1.rx_data; end
            end
            if (cs1 === 1'b1 && cs_hi < 0) cs_hi = k;
        end
        chk("b2b_pulse_count", np, 2);
        chk("b2b_first_pulse", p1, 17);
        chk("b2b_second_pulse", p2, 34);
        chk("b2b_rx1", rx1, 8'h00);
        chk("b2b_rx2", rx2, 8'h00);
        chk("b2b_cs_rise", cs_hi, 35);
        chk("b2b_idle_pins", {sclk1, mosi1, fa1}, 3'b000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
